// File: rtl/free_list_pkg.sv
// free_list_pkg: shared rename sizing (PRF/ARF/free-list widths) and free-list pointer helpers.
package free_list_pkg;
    localparam int RENAME_WIDTH       = 4;
    localparam int PRF_INT_SIZE       = 64;
    localparam int ARF_INT_SIZE       = 32;
    localparam int FL_SIZE            = PRF_INT_SIZE - ARF_INT_SIZE;
    localparam int PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE);
    localparam int FL_IDX_SIZE        = $clog2(FL_SIZE);
    localparam int FL_PTR_SIZE        = FL_IDX_SIZE + 1;
    localparam int LANE_CNT_SIZE      = $clog2(RENAME_WIDTH + 1);

    typedef logic [FL_PTR_SIZE-1:0]        fl_ptr_t;
    typedef logic [PRF_INT_INDEX_SIZE-1:0] prf_idx_t;
    typedef logic [LANE_CNT_SIZE-1:0]      lane_cnt_t;

    // Storage slot reached by stepping off entries past ptr; the wrap bit drops out.
    function automatic logic [FL_IDX_SIZE-1:0] fl_slot(input fl_ptr_t ptr, input lane_cnt_t off);
        return FL_IDX_SIZE'(ptr + fl_ptr_t'(off));
    endfunction
endpackage

// File: rtl/popcount_prefix.sv
// popcount_prefix: per-lane count of set mask bits below each lane, plus the total.
module popcount_prefix
    import free_list_pkg::*;
(
    input  logic [RENAME_WIDTH-1:0]      mask,
    output lane_cnt_t [RENAME_WIDTH-1:0] prefix,
    output lane_cnt_t                    total
);
    always_comb begin
        total = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            prefix[i] = total;
            total     = total + lane_cnt_t'(mask[i]);
        end
    end
endmodule

// File: rtl/free_list.sv
// free_list: circular free-PRF list feeding rename; compacted multi-lane alloc/release with
// head snapshot recovery for branch mispredicts.
module free_list
    import free_list_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [RENAME_WIDTH-1:0]        alloc_req,
    input  logic                           alloc_en,
    output prf_idx_t [RENAME_WIDTH-1:0]    alloc_prf,
    output logic                           allocatable,
    input  logic [RENAME_WIDTH-1:0]        release_valid,
    input  prf_idx_t [RENAME_WIDTH-1:0]    release_prf,
    input  logic                           recover,
    input  fl_ptr_t                        recover_head,
    output fl_ptr_t                        ckpt_head,
    output fl_ptr_t                        free_count,
    output logic                           overflow
);
    localparam int CMP_W = FL_PTR_SIZE + 1;

    prf_idx_t entries_q [FL_SIZE];
    prf_idx_t entries_d [FL_SIZE];
    fl_ptr_t  head_q, head_d, tail_q, tail_d;
    logic     overflow_q, overflow_d;
    logic     fire, rel_ok;

    lane_cnt_t [RENAME_WIDTH-1:0] alloc_pre, rel_pre;
    lane_cnt_t                    alloc_total, rel_total;

    popcount_prefix u_alloc_cnt (.mask(alloc_req),     .prefix(alloc_pre), .total(alloc_total));
    popcount_prefix u_rel_cnt   (.mask(release_valid), .prefix(rel_pre),   .total(rel_total));

    assign ckpt_head = head_q;
    assign overflow  = overflow_q;

    // Releases are judged against the pre-edge count, so a same-cycle allocation never makes room.
    always_comb begin
        free_count  = tail_q - head_q;
        allocatable = (alloc_req == '0) || (fl_ptr_t'(alloc_total) <= free_count);
        fire        = alloc_en & allocatable & ~recover;
        rel_ok      = ({1'b0, free_count} + CMP_W'(rel_total)) <= CMP_W'(FL_SIZE);
        head_d      = recover ? recover_head : fire ? head_q + fl_ptr_t'(alloc_total) : head_q;
        tail_d      = rel_ok ? tail_q + fl_ptr_t'(rel_total) : tail_q;
        overflow_d  = overflow_q | ~rel_ok;
        entries_d   = entries_q;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            alloc_prf[i] = alloc_req[i] ? entries_q[fl_slot(head_q, alloc_pre[i])] : '0;
            if (rel_ok && release_valid[i])
                entries_d[fl_slot(tail_q, rel_pre[i])] = release_prf[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FL_SIZE; k++)
                entries_q[k] <= prf_idx_t'(ARF_INT_SIZE + k);
            head_q     <= '0;
            tail_q     <= fl_ptr_t'(FL_SIZE);
            overflow_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list; expected grants come from a FIFO model of the list.
module tb_free_list;
    import free_list_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [3:0]           alloc_req = '0;
    logic                 alloc_en = 1'b0;
    logic [3:0][5:0]      alloc_prf;
    logic                 allocatable;
    logic [3:0]           release_valid = '0;
    logic [3:0][5:0]      release_prf = '0;
    logic                 recover = 1'b0;
    logic [5:0]           recover_head = '0;
    logic [5:0]           ckpt_head;
    logic [5:0]           free_count;
    logic                 overflow;

    always #5 clock = ~clock;

    free_list dut (
        .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_en(alloc_en),
        .alloc_prf(alloc_prf), .allocatable(allocatable), .release_valid(release_valid),
        .release_prf(release_prf), .recover(recover), .recover_head(recover_head),
        .ckpt_head(ckpt_head), .free_count(free_count), .overflow(overflow)
    );

    typedef struct {
        logic [3:0][5:0] prf;
        logic            ok;
    } exp_t;

    exp_t exp_q[$];
    int   m_mem[32];
    int   mh, mt;
    bit   m_ovf;
    logic [3:0]      s_req, s_rv;
    logic            s_en, s_rec, s_ok;
    logic [3:0][5:0] s_rp;
    int   s_rh;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic int m_count();
        return (mt - mh + 64) % 64;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_mem[k] = 32 + k;
        mh = 0;
        mt = 32;
        m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        alloc_req = '0; alloc_en = 1'b0; release_valid = '0; release_prf = '0;
        recover = 1'b0; recover_head = '0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives one cycle of stimulus and pushes the grant the model predicts for it.
    task automatic drive(input logic [3:0] req, input logic en, input logic [3:0] rv,
                         input logic [3:0][5:0] rp, input logic rec, input int rh);
        exp_t e;
        int   off;
        int   n;
        @(negedge clock);
        alloc_req = req; alloc_en = en; release_valid = rv; release_prf = rp;
        recover = rec; recover_head = 6'(rh);
        n = $countones(req);
        off = 0;
        e.ok = (n == 0) || (n <= m_count());
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                e.prf[i] = 6'(m_mem[(mh + off) % 32]);
                off++;
            end else e.prf[i] = '0;
        end
        exp_q.push_back(e);
        s_req = req; s_en = en; s_rv = rv; s_rp = rp; s_rec = rec; s_rh = rh; s_ok = e.ok;
    endtask

    task automatic tick();
        int r;
        int off;
        @(posedge clock);
        r = $countones(s_rv);
        if (m_count() + r > 32) m_ovf = 1;
        else begin
            off = 0;
            for (int i = 0; i < 4; i++) begin
                if (s_rv[i]) begin
                    m_mem[(mt + off) % 32] = int'(s_rp[i]);
                    off++;
                end
            end
            mt = (mt + r) % 64;
        end
        if (s_rec) mh = s_rh;
        else if (s_en && s_ok) mh = (mh + $countones(s_req)) % 64;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        n_checks++;
        if (free_count !== 6'd32 || ckpt_head !== 6'd0 || overflow !== 1'b0 || allocatable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state cnt=%0d head=%0d ovf=%b ok=%b want 32 0 0 1",
                     free_count, ckpt_head, overflow, allocatable);
        end
        drive(4'b1111, 1'b1, '0, '0, 1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (free_count !== 6'd32 || ckpt_head !== 6'd0 || alloc_prf !== e.prf) begin
            n_fail++;
            $display("FAIL reset_midop cnt=%0d head=%0d prf=%h want 32 0 %h",
                     free_count, ckpt_head, alloc_prf, e.prf);
        end
        do_reset();
        n_checks++;
        if (free_count !== 6'd32 || ckpt_head !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_after cnt=%0d head=%0d want 32 0", free_count, ckpt_head);
        end
    endtask

    task automatic test_alloc_all();
        exp_t e;
        do_reset();
        drive(4'b1111, 1'b1, '0, '0, 1'b0, 0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (alloc_prf !== {6'd35, 6'd34, 6'd33, 6'd32} || alloc_prf !== e.prf) begin
            n_fail++;
            $display("FAIL alloc_all prf=%h want %h", alloc_prf, {6'd35, 6'd34, 6'd33, 6'd32});
        end
        tick();
        n_checks++;
        if (free_count !== 6'd28) begin
            n_fail++;
            $display("FAIL alloc_all_count cnt=%0d want 28", free_count);
        end
    endtask

    task automatic test_sparse();
        exp_t e;
        do_reset();
        drive(4'b1010, 1'b1, '0, '0, 1'b0, 0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (alloc_prf !== {6'd33, 6'd0, 6'd32, 6'd0} || alloc_prf !== e.prf) begin
            n_fail++;
            $display("FAIL sparse prf=%h want %h", alloc_prf, {6'd33, 6'd0, 6'd32, 6'd0});
        end
        tick();
        n_checks++;
        if (free_count !== 6'd30) begin
            n_fail++;
            $display("FAIL sparse_count cnt=%0d want 30", free_count);
        end
    endtask

    task automatic test_empty();
        exp_t e;
        do_reset();
        for (int g = 0; g < 8; g++) begin
            drive(4'b1111, 1'b1, '0, '0, 1'b0, 0);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (alloc_prf !== e.prf || allocatable !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_group%0d prf=%h ok=%b want %h 1", g, alloc_prf, allocatable, e.prf);
            end
            tick();
        end
        n_checks++;
        if (free_count !== 6'd0) begin
            n_fail++;
            $display("FAIL empty_count cnt=%0d want 0", free_count);
        end
        drive(4'b0001, 1'b1, '0, '0, 1'b0, 0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (allocatable !== 1'b0 || allocatable !== e.ok) begin
            n_fail++;
            $display("FAIL empty_allocatable ok=%b want 0", allocatable);
        end
        tick();
        n_checks++;
        if (ckpt_head !== 6'd32 || free_count !== 6'd0) begin
            n_fail++;
            $display("FAIL empty_head head=%0d cnt=%0d want 32 0", ckpt_head, free_count);
        end
    endtask

    task automatic test_recover();
        exp_t e;
        logic [5:0] ck;
        do_reset();
        drive(4'b1111, 1'b1, '0, '0, 1'b0, 0);
        tick();
        ck = ckpt_head;
        n_checks++;
        if (ck !== 6'd4) begin
            n_fail++;
            $display("FAIL ckpt_capture head=%0d want 4", ck);
        end
        repeat (2) begin
            drive(4'b1111, 1'b1, '0, '0, 1'b0, 0);
            tick();
        end
        drive(4'b1111, 1'b1, '0, '0, 1'b1, int'(ck));
        tick();
        n_checks++;
        if (free_count !== 6'd28 || free_count !== 6'(m_count())) begin
            n_fail++;
            $display("FAIL recover_count cnt=%0d want 28", free_count);
        end
        exp_q.delete();
        drive(4'b0001, 1'b1, '0, '0, 1'b0, 0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (alloc_prf[0] !== 6'd36 || alloc_prf !== e.prf) begin
            n_fail++;
            $display("FAIL recover_grant prf0=%0d want 36", alloc_prf[0]);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [3:0][5:0] rp;
        do_reset();
        rp = '0;
        rp[0] = 6'd5;
        drive(4'b0000, 1'b0, 4'b0001, rp, 1'b0, 0);
        tick();
        n_checks++;
        if (overflow !== 1'b1 || free_count !== 6'd32 || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL overflow ovf=%b cnt=%0d want 1 32", overflow, free_count);
        end
        drive(4'b0000, 1'b0, 4'b0000, '0, 1'b0, 0);
        tick();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky ovf=%b want 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0][5:0] rp;
        do_reset();
        repeat (7) begin
            drive(4'b1111, 1'b1, '0, '0, 1'b0, 0);
            tick();
        end
        drive(4'b0011, 1'b1, '0, '0, 1'b0, 0);
        tick();
        exp_q.delete();
        rp = '0;
        rp[0] = 6'd5;
        rp[1] = 6'd6;
        drive(4'b0011, 1'b1, 4'b0011, rp, 1'b0, 0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (alloc_prf !== {6'd0, 6'd0, 6'd63, 6'd62} || alloc_prf !== e.prf) begin
            n_fail++;
            $display("FAIL b2b_grant prf=%h want %h", alloc_prf, {6'd0, 6'd0, 6'd63, 6'd62});
        end
        tick();
        n_checks++;
        if (free_count !== 6'd2) begin
            n_fail++;
            $display("FAIL b2b_count cnt=%0d want 2", free_count);
        end
        drive(4'b0011, 1'b1, '0, '0, 1'b0, 0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (alloc_prf[0] !== 6'd5 || alloc_prf[1] !== 6'd6 || alloc_prf !== e.prf) begin
            n_fail++;
            $display("FAIL b2b_reuse prf0=%0d prf1=%0d want 5 6", alloc_prf[0], alloc_prf[1]);
        end
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        logic [3:0][5:0] rp;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) rp[i] = 6'($urandom_range(0, 63));
            drive(4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                  rp, 1'b0, 0);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (alloc_prf !== e.prf || allocatable !== e.ok) begin
                n_fail++;
                $display("FAIL random_grant c=%0d prf=%h ok=%b want %h %b", c, alloc_prf, allocatable, e.prf, e.ok);
            end
            tick();
            n_checks++;
            if (free_count !== 6'(m_count()) || overflow !== m_ovf || ckpt_head !== 6'(mh)) begin
                n_fail++;
                $display("FAIL random_state c=%0d cnt=%0d ovf=%b head=%0d want %0d %b %0d",
                         c, free_count, overflow, ckpt_head, m_count(), m_ovf, mh);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alloc_all();
        test_sparse();
        test_empty();
        test_recover();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
